// File: rtl/rv_fp_fclass_unit_pkg.sv
// Shared FPU constants for FCLASS.S: class-vector bit positions produced by RV_fp_class
// and bit positions of the architectural 10-bit FCLASS result mask.
package rv_fp_fclass_unit_pkg;

    localparam int CLS_WIDTH    = 7;
    localparam int FCLASS_WIDTH = 10;

    localparam int CLS_NORMAL    = 6;
    localparam int CLS_ZERO      = 5;
    localparam int CLS_SUBNORMAL = 4;
    localparam int CLS_INF       = 3;
    localparam int CLS_NAN       = 2;
    localparam int CLS_QUIET     = 1;
    localparam int CLS_SIGNALING = 0;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    typedef logic [CLS_WIDTH-1:0]    cls_vec_t;
    typedef logic [FCLASS_WIDTH-1:0] fclass_mask_t;

endpackage

// File: rtl/rv_fp_fclass_unit_class.sv
// Single-operand IEEE-754 classifier: turns exponent/mantissa fields into the
// 7-bit class vector (normal, zero, subnormal, inf, nan, quiet, signaling).
import rv_fp_fclass_unit_pkg::*;

module RV_fp_class #(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23
) (
    input  logic [EXP_BITS-1:0] exp_i,
    input  logic [MAN_BITS-1:0] man_i,
    output cls_vec_t            class_o
);

    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic is_nan;

    always_comb begin
        exp_ones = &exp_i;
        exp_zero = ~|exp_i;
        man_zero = ~|man_i;
        is_nan   = exp_ones & ~man_zero;

        class_o                = '0;
        class_o[CLS_NORMAL]    = ~exp_ones & ~exp_zero;
        class_o[CLS_ZERO]      = exp_zero & man_zero;
        class_o[CLS_SUBNORMAL] = exp_zero & ~man_zero;
        class_o[CLS_INF]       = exp_ones & man_zero;
        class_o[CLS_NAN]       = is_nan;
        // Quiet/signaling is decided by the mantissa MSB only; sign plays no part.
        class_o[CLS_QUIET]     = is_nan & man_i[MAN_BITS-1];
        class_o[CLS_SIGNALING] = is_nan & ~man_i[MAN_BITS-1];
    end

endmodule

// File: rtl/rv_fp_fclass_unit.sv
// Multi-lane, two-stage FCLASS.S unit: S1 holds sign + class vector per lane,
// S2 holds the encoded, zero-extended FCLASS masks and signaling-NaN flags.
import rv_fp_fclass_unit_pkg::*;

module rv_fp_fclass_unit #(
    parameter int NUM_LANES = 4,
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    input  logic [NUM_LANES-1:0]      lane_mask,
    input  logic [NUM_LANES*XLEN-1:0] dataa,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic [NUM_LANES*XLEN-1:0] result,
    output logic [NUM_LANES-1:0]      has_snan
);

    function automatic fclass_mask_t fclass_encode(input logic sign, input cls_vec_t cls);
        fclass_mask_t m;
        m = '0;
        if (cls[CLS_NAN]) begin
            if (cls[CLS_QUIET]) m[FCLASS_QNAN] = 1'b1;
            else                m[FCLASS_SNAN] = 1'b1;
        end else if (cls[CLS_INF]) begin
            if (sign) m[FCLASS_NEG_INF] = 1'b1;
            else      m[FCLASS_POS_INF] = 1'b1;
        end else if (cls[CLS_NORMAL]) begin
            if (sign) m[FCLASS_NEG_NORM] = 1'b1;
            else      m[FCLASS_POS_NORM] = 1'b1;
        end else if (cls[CLS_SUBNORMAL]) begin
            if (sign) m[FCLASS_NEG_SUB] = 1'b1;
            else      m[FCLASS_POS_SUB] = 1'b1;
        end else if (cls[CLS_ZERO]) begin
            if (sign) m[FCLASS_NEG_ZERO] = 1'b1;
            else      m[FCLASS_POS_ZERO] = 1'b1;
        end
        return m;
    endfunction

    logic                       s1_valid_q;
    logic [TAG_WIDTH-1:0]       s1_tag_q;
    logic [NUM_LANES-1:0]       s1_mask_q;
    logic [NUM_LANES-1:0]       s1_sign_q;
    cls_vec_t [NUM_LANES-1:0]   s1_cls_q;

    logic                       s2_valid_q;
    logic [TAG_WIDTH-1:0]       s2_tag_q;
    logic [NUM_LANES*XLEN-1:0]  s2_result_q;
    logic [NUM_LANES*XLEN-1:0]  s2_result_d;
    logic [NUM_LANES-1:0]       s2_snan_q;
    logic [NUM_LANES-1:0]       s2_snan_d;

    logic [NUM_LANES-1:0]       sign_w;
    cls_vec_t [NUM_LANES-1:0]   cls_w;
    logic                       stall;

    // Handshake: an output transfer is valid_out & ready_out, an input transfer is
    // valid_in & ready_in. A presented but unaccepted result freezes both stages, so
    // ready_in drops only then; bubbles in S1 still advance and are not collapsed.
    assign stall    = s2_valid_q & ~ready_out;
    assign ready_in = ~stall;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign sign_w[gi] = dataa[gi*XLEN + EXP_BITS + MAN_BITS];

        RV_fp_class #(
            .EXP_BITS (EXP_BITS),
            .MAN_BITS (MAN_BITS)
        ) u_class (
            .exp_i   (dataa[gi*XLEN + MAN_BITS +: EXP_BITS]),
            .man_i   (dataa[gi*XLEN +: MAN_BITS]),
            .class_o (cls_w[gi])
        );
    end

    always_comb begin
        s2_result_d = '0;
        s2_snan_d   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (s1_mask_q[i]) begin
                s2_result_d[i*XLEN +: FCLASS_WIDTH] = fclass_encode(s1_sign_q[i], s1_cls_q[i]);
                s2_snan_d[i] = s1_cls_q[i][CLS_SIGNALING];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_mask_q   <= '0;
            s1_sign_q   <= '0;
            s1_cls_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            s2_result_q <= '0;
            s2_snan_q   <= '0;
        end else if (!stall) begin
            s1_valid_q  <= valid_in;
            s1_tag_q    <= tag_in;
            s1_mask_q   <= lane_mask;
            s1_sign_q   <= sign_w;
            s1_cls_q    <= cls_w;
            s2_valid_q  <= s1_valid_q;
            s2_tag_q    <= s1_tag_q;
            s2_result_q <= s2_result_d;
            s2_snan_q   <= s2_snan_d;
        end
    end

    assign valid_out = s2_valid_q;
    assign tag_out   = s2_tag_q;
    assign result    = s2_result_q;
    assign has_snan  = s2_snan_q;

endmodule

// File: tb/tb_rv_fp_fclass_unit.sv
// Bench for rv_fp_fclass_unit: directed vector table, back-pressure, mid-flight reset
// and a randomized stream scored against an independent FCLASS model.
module tb_rv_fp_fclass_unit;

    localparam int NL = 4;
    localparam int XL = 32;
    localparam int TW = 8;
    localparam int W  = TW + NL*XL + NL;

    logic               clk = 1'b0;
    logic               reset;
    logic               valid_in;
    logic               ready_in;
    logic [TW-1:0]      tag_in;
    logic [NL-1:0]      lane_mask;
    logic [NL*XL-1:0]   dataa;
    logic               valid_out;
    logic               ready_out;
    logic [TW-1:0]      tag_out;
    logic [NL*XL-1:0]   result;
    logic [NL-1:0]      has_snan;

    int tests = 0;
    int fails = 0;

    logic [W-1:0]  exp_q[$];
    logic [TW-1:0] got_tags[$];
    logic          mon_en = 1'b0;
    logic          stall_prev = 1'b0;
    logic [W-1:0]  stall_word;
    logic          stream_on = 1'b0;

    rv_fp_fclass_unit #(
        .NUM_LANES (NL), .EXP_BITS (8), .MAN_BITS (23), .XLEN (XL), .TAG_WIDTH (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .tag_in    (tag_in),
        .lane_mask (lane_mask),
        .dataa     (dataa),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .tag_out   (tag_out),
        .result    (result),
        .has_snan  (has_snan)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference FCLASS for binary32, straight from the field definitions.
    function automatic logic [9:0] ref_fclass(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        int          idx;
        s = x[31];
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF) begin
            if (m == 0) idx = s ? 0 : 7;
            else        idx = m[22] ? 9 : 8;
        end else if (e == 8'h00) begin
            if (m == 0) idx = s ? 3 : 4;
            else        idx = s ? 2 : 5;
        end else begin
            idx = s ? 1 : 6;
        end
        return 10'(1) << idx;
    endfunction

    function automatic logic [W-1:0] ref_txn(input logic [TW-1:0] t, input logic [NL*XL-1:0] d,
                                             input logic [NL-1:0] msk);
        logic [NL*XL-1:0] r;
        logic [NL-1:0]    sn;
        logic [9:0]       c;
        r  = '0;
        sn = '0;
        for (int i = 0; i < NL; i++) begin
            if (msk[i]) begin
                c = ref_fclass(d[i*XL +: XL]);
                r[i*XL +: XL] = {22'b0, c};
                sn[i] = c[8];
            end
        end
        return {t, r, sn};
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 6))
            0: return {s, 31'b0};
            1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
            2: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            3: return {s, 8'hFF, 23'b0};
            4: return {s, 8'hFF, 1'b1, 22'($urandom)};
            5: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
            default: return $urandom;
        endcase
    endfunction

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [TW-1:0] t, input logic [NL*XL-1:0] d, input logic [NL-1:0] msk);
        logic rdy;
        logic accepted;
        valid_in  = 1'b1;
        tag_in    = t;
        dataa     = d;
        lane_mask = msk;
        accepted  = 1'b0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            rdy = ready_in;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        if (accepted) begin
            exp_q.push_back(ref_txn(t, d, msk));
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: tag %0h not accepted within 200 cycles", t);
        end
        valid_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (stall_prev) begin
                check("stall_valid_hold", 160'(valid_out), 160'(1));
                check("stall_data_hold", 160'({tag_out, result, has_snan}), 160'(stall_word));
            end
            if (valid_out && ready_out) begin
                got_tags.push_back(tag_out);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: tag %0h with no expected entry", tag_out);
                end else begin
                    check("stream_out", 160'({tag_out, result, has_snan}), 160'(exp_q.pop_front()));
                end
            end
            stall_prev = valid_out && !ready_out;
            if (stall_prev) begin
                stall_word = {tag_out, result, has_snan};
                check("stall_ready_in", 160'(ready_in), 160'(0));
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (stream_on) begin
            #1 ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic [NL*XL-1:0] data;
        logic [NL-1:0]    mask;
        logic [NL*XL-1:0] exp_res;
        logic [NL-1:0]    exp_snan;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit seen;
        bit drained;

        tbl[0].data = {32'hFF800000, 32'h7F800000, 32'h80000000, 32'h00000000};
        tbl[0].mask = 4'hF;
        tbl[0].exp_res = {32'h001, 32'h080, 32'h008, 32'h010};
        tbl[0].exp_snan = 4'b0000;
        tbl[1].data = {32'h807FFFFF, 32'h00000001, 32'hBF800000, 32'h3F800000};
        tbl[1].mask = 4'hF;
        tbl[1].exp_res = {32'h004, 32'h020, 32'h002, 32'h040};
        tbl[1].exp_snan = 4'b0000;
        tbl[2].data = {32'hFF800001, 32'h7FC00000, 32'hFF800001, 32'h7FC00000};
        tbl[2].mask = 4'hF;
        tbl[2].exp_res = {32'h100, 32'h200, 32'h100, 32'h200};
        tbl[2].exp_snan = 4'b1010;
        tbl[3].data = {4{32'h7F800001}};
        tbl[3].mask = 4'b0101;
        tbl[3].exp_res = {32'h000, 32'h100, 32'h000, 32'h100};
        tbl[3].exp_snan = 4'b0101;
        tbl[4].data = {32'hFFBFFFFF, 32'h7FFFFFFF, 32'h00800000, 32'h7F7FFFFF};
        tbl[4].mask = 4'hF;
        tbl[4].exp_res = {32'h100, 32'h200, 32'h040, 32'h040};
        tbl[4].exp_snan = 4'b1000;

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        tag_in = '0; lane_mask = '0; dataa = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready_in", 160'(ready_in), 160'(1));
        check("reset_valid_out", 160'(valid_out), 160'(0));
        check("reset_tag_out", 160'(tag_out), 160'(0));
        check("reset_result", 160'(result), 160'(0));
        check("reset_has_snan", 160'(has_snan), 160'(0));

        // Directed vectors: exactly two cycles of latency with ready_out held high.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1; tag_in = 8'(8'h10 + i);
            dataa = tbl[i].data; lane_mask = tbl[i].mask;
            @(posedge clk);
            #1 valid_in = 1'b0;
            @(negedge clk);
            check("tbl_not_early", 160'(valid_out), 160'(0));
            @(negedge clk);
            check("tbl_valid", 160'(valid_out), 160'(1));
            check("tbl_tag", 160'(tag_out), 160'(8'h10 + i));
            check("tbl_result", 160'(result), 160'(tbl[i].exp_res));
            check("tbl_snan", 160'(has_snan), 160'(tbl[i].exp_snan));
        end

        // Back-pressure: four back-to-back tags, five stalled cycles once output appears.
        @(posedge clk);
        #1;
        exp_q.delete(); got_tags.delete();
        ready_out = 1'b0;
        mon_en = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                for (int t = 1; t <= 4; t++) send(8'(t), {4{32'h3F800000}}, 4'hF);
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (valid_out) seen = 1'b1;
                end
                check("bp_first_valid", 160'(seen), 160'(1));
                repeat (5) @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drained = 1'b0;
        for (int c = 0; c < 50 && !drained; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        check("bp_drained", 160'(drained), 160'(1));
        check("bp_count", 160'(got_tags.size()), 160'(4));
        for (int i = 0; i < got_tags.size() && i < 4; i++)
            check("bp_order", 160'(got_tags[i]), 160'(i + 1));

        // Mid-flight reset with both stages holding valid requests.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        ready_out = 1'b0;
        valid_in = 1'b1; tag_in = 8'hA1; dataa = {4{32'h3F800000}}; lane_mask = 4'hF;
        @(posedge clk);
        #1 tag_in = 8'hA2;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", 160'(valid_out), 160'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid_out", 160'(valid_out), 160'(0));
        check("rst_ready_in", 160'(ready_in), 160'(1));
        check("rst_tag_out", 160'(tag_out), 160'(0));
        ready_out = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_no_stale", 160'(valid_out), 160'(0));
        end

        // Randomized stream with random back-pressure and input gaps.
        @(posedge clk);
        #1;
        exp_q.delete(); got_tags.delete();
        mon_en = 1'b1;
        stream_on = 1'b1;
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(8'(n), {rand_op(), rand_op(), rand_op(), rand_op()}, 4'($urandom_range(0, 15)));
        end
        drained = 1'b0;
        for (int c = 0; c < 200 && !drained; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        stream_on = 1'b0;
        @(posedge clk);
        #2 ready_out = 1'b1;
        check("stream_drained", 160'(drained), 160'(1));
        check("stream_count", 160'(got_tags.size()), 160'(100));
        for (int i = 0; i < got_tags.size() && i < 100; i++)
            check("stream_order", 160'(got_tags[i]), 160'(i));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
